// File: rtl/chk_result_logger.sv
// Logs the results of an upstream equality check: pass/fail counters, and a show-ahead FIFO of
// timestamped failure records. Define CHK_LOG_PASS_EN to log passes as well (adds the rec_pass port).
module chk_result_logger #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int TSW   = 16,
    parameter int CW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           chk_valid,
    output logic           chk_ready,
    input  logic           chk_pass,
    input  logic [W-1:0]   chk_a,
    input  logic [W-1:0]   chk_b,
    input  logic           halt_on_fail,
    input  logic           resume,
    output logic           rec_valid,
    input  logic           rec_ready,
    output logic [TSW-1:0] rec_time,
    output logic [W-1:0]   rec_a,
    output logic [W-1:0]   rec_b,
`ifdef CHK_LOG_PASS_EN
    output logic           rec_pass,
`endif
    output logic [CW-1:0]  pass_cnt,
    output logic [CW-1:0]  fail_cnt,
    output logic           halted,
    output logic           overflow
);

    // state     | meaning
    // ST_RUN    | accepting check events
    // ST_HALTED | stopped after a failure with halt_on_fail; waits for resume
    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    localparam int AW = $clog2(DEPTH);

    state_t          state_q, state_d;
    logic [TSW-1:0]  ts_q, ts_d;
    logic [CW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;

    logic [TSW-1:0]  mem_ts_q [DEPTH];
    logic [W-1:0]    mem_a_q  [DEPTH];
    logic [W-1:0]    mem_b_q  [DEPTH];
`ifdef CHK_LOG_PASS_EN
    logic            mem_p_q  [DEPTH];
`endif

    logic accept, push_req, push, pop, empty, full;

    assign chk_ready = (state_q == ST_RUN);
    assign accept    = chk_valid & chk_ready;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = ~empty & rec_ready;
`ifdef CHK_LOG_PASS_EN
    assign push_req  = accept;
`else
    assign push_req  = accept & ~chk_pass;
`endif
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push      = push_req & (~full | pop);

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + TSW'(1);
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_RUN:    if (accept && !chk_pass && halt_on_fail) state_d = ST_HALTED;
            ST_HALTED: if (resume) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        if (accept && chk_pass && pass_cnt_q != {CW{1'b1}})
            pass_cnt_d = pass_cnt_q + CW'(1);
        if (accept && !chk_pass && fail_cnt_q != {CW{1'b1}})
            fail_cnt_d = fail_cnt_q + CW'(1);

        if (push)
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (push_req && !push)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ts_q       <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage needs no reset; empty masking hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts_q[wr_ptr_q[AW-1:0]] <= ts_q;
            mem_a_q[wr_ptr_q[AW-1:0]]  <= chk_a;
            mem_b_q[wr_ptr_q[AW-1:0]]  <= chk_b;
`ifdef CHK_LOG_PASS_EN
            mem_p_q[wr_ptr_q[AW-1:0]]  <= chk_pass;
`endif
        end
    end

    assign rec_valid = ~empty;
    assign rec_time  = empty ? '0 : mem_ts_q[rd_ptr_q[AW-1:0]];
    assign rec_a     = empty ? '0 : mem_a_q[rd_ptr_q[AW-1:0]];
    assign rec_b     = empty ? '0 : mem_b_q[rd_ptr_q[AW-1:0]];
`ifdef CHK_LOG_PASS_EN
    assign rec_pass  = empty ? 1'b0 : mem_p_q[rd_ptr_q[AW-1:0]];
`endif
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign halted    = (state_q == ST_HALTED);
    assign overflow  = overflow_q;

endmodule
